// File: rtl/pit_if.sv
// Bus bundle between the interrupt-controller side and the programmable interval timer.
// The master drives the write/ack strobes and the slave returns the live counts and interrupt flags.
interface pit_if;
  logic [15:0] din;
  logic        pre_wr;
  logic        div_wr;
  logic        int_ack;
  logic [15:0] pre_q;
  logic [15:0] div_q;
  logic        pit_int;
  logic        int_pend;

  modport master (
    output din, pre_wr, div_wr, int_ack,
    input  pre_q, div_q, pit_int, int_pend
  );

  modport slave (
    input  din, pre_wr, div_wr, int_ack,
    output pre_q, div_q, pit_int, int_pend
  );
endinterface

// File: rtl/pit_timer.sv
// Programmable interval timer: a 16-bit prescaler whose borrow steps a 16-bit divider.
// The divider's terminal count produces a one-cycle interrupt pulse and a sticky pending flag.
module pit_timer (
  input  logic  clk,
  input  logic  resl,
  pit_if.slave  bus
);

  logic [15:0] pre_rld;
  logic [15:0] div_rld;
  logic [15:0] pre_cnt;
  logic [15:0] div_cnt;
  logic        pit_int_r;
  logic        int_pend_r;

  logic run;
  logic pre_bo;
  logic term;
  logic fire;

  // NOTE: borrow and term come from the pre-write state, so a write never hides a borrow already due.
  assign run    = (pre_rld != 16'd0);
  assign pre_bo = run && (pre_cnt == 16'd0);
  assign term   = pre_bo && (div_cnt == 16'd0);
  assign fire   = term && !bus.div_wr;

  // NOTE: all state is registered with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      pre_rld    <= 16'd0;
      div_rld    <= 16'd0;
      pre_cnt    <= 16'd0;
      div_cnt    <= 16'd0;
      pit_int_r  <= 1'b0;
      int_pend_r <= 1'b0;
    end else begin
      if (bus.pre_wr) begin
        pre_rld <= bus.din;
        pre_cnt <= bus.din;
      end else if (run) begin
        pre_cnt <= (pre_cnt == 16'd0) ? pre_rld : pre_cnt - 16'd1;
      end

      if (bus.div_wr) begin
        div_rld <= bus.din;
        div_cnt <= bus.din;
      end else if (pre_bo) begin
        div_cnt <= (div_cnt == 16'd0) ? div_rld : div_cnt - 16'd1;
      end

      pit_int_r <= fire;

      // NOTE: a terminal count landing with int_ack keeps the flag set; the ack only clears it otherwise.
      if (fire) begin
        int_pend_r <= 1'b1;
      end else if (bus.int_ack) begin
        int_pend_r <= 1'b0;
      end
    end
  end

  assign bus.pre_q    = pre_cnt;
  assign bus.div_q    = div_cnt;
  assign bus.pit_int  = pit_int_r;
  assign bus.int_pend = int_pend_r;

endmodule

// File: tb/tb_pit_timer.sv
// Self-checking bench for pit_timer: a cycle model pushes expected outputs to a scoreboard,
// popped and compared one clock later, plus direct period and collision checks.
module tb_pit_timer;

  typedef struct packed {
    logic [15:0] pre_q;
    logic [15:0] div_q;
    logic        pit_int;
    logic        int_pend;
  } obs_t;

  logic clk;
  logic resl;
  pit_if bus ();

  pit_timer dut (
    .clk  (clk),
    .resl (resl),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  obs_t exp_q[$];

  // Reference model state
  int m_pre_rld, m_div_rld, m_pre, m_div;
  bit m_int, m_pend;

  // Pulse tracking
  int cyc = 0;
  int last_pulse = -1;
  int last_gap = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre_rld = 0; m_div_rld = 0; m_pre = 0; m_div = 0;
    m_int = 0; m_pend = 0;
  endtask

  task automatic clear_pulses();
    last_pulse = -1;
    last_gap   = 0;
    pulses     = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic step(input bit pw, input bit dw, input bit ack, input int d);
    bit run, bo, term;
    int n_pre, n_div;
    obs_t e, got;
    bus.pre_wr  = pw;
    bus.div_wr  = dw;
    bus.int_ack = ack;
    bus.din     = d[15:0];
    if (resl) begin
      run   = (m_pre_rld != 0);
      bo    = run && (m_pre == 0);
      term  = bo && (m_div == 0);
      n_pre = m_pre;
      n_div = m_div;
      if (run)  n_pre = (m_pre == 0) ? m_pre_rld : m_pre - 1;
      if (bo)   n_div = (m_div == 0) ? m_div_rld : m_div - 1;
      if (pw) begin n_pre = d; m_pre_rld = d; end
      if (dw) begin n_div = d; m_div_rld = d; end
      m_pre = n_pre;
      m_div = n_div;
      m_int = term && !dw;
      if (term && !dw)  m_pend = 1;
      else if (ack)     m_pend = 0;
    end
    e.pre_q = m_pre[15:0]; e.div_q = m_div[15:0];
    e.pit_int = m_int;     e.int_pend = m_pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got.pre_q = bus.pre_q; got.div_q = bus.div_q;
    got.pit_int = bus.pit_int; got.int_pend = bus.int_pend;
    e = exp_q.pop_front();
    check("pre_q",    {16'd0, got.pre_q}, {16'd0, e.pre_q});
    check("div_q",    {16'd0, got.div_q}, {16'd0, e.div_q});
    check("pit_int",  {31'd0, got.pit_int}, {31'd0, e.pit_int});
    check("int_pend", {31'd0, got.int_pend}, {31'd0, e.int_pend});
    if (got.pit_int) begin
      if (last_pulse >= 0) last_gap = cyc - last_pulse;
      last_pulse = cyc;
      pulses++;
    end
    bus.pre_wr = 0; bus.div_wr = 0; bus.int_ack = 0; bus.din = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Advance until the model says the current cycle is a terminal-count cycle.
  task automatic goto_term(input string tag);
    int n = 0;
    while (!(m_pre_rld != 0 && m_pre == 0 && m_div == 0) && n < 300) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (n >= 300) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    int p0 = pulses;
    while (pulses == p0 && n < 300) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (n >= 300) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int exp_seq[6];
    int frz;
    exp_seq = '{2, 2, 1, 1, 0, 0};
    resl = 1'b0;
    bus.pre_wr = 0; bus.div_wr = 0; bus.int_ack = 0; bus.din = '0;
    model_reset();

    // Reset held with writes active
    for (int i = 0; i < 3; i++) step(1, 1, 0, 5);
    check("rst_pre_q", {16'd0, bus.pre_q}, 32'd0);
    check("rst_int_pend", {31'd0, bus.int_pend}, 32'd0);
    resl = 1'b1;
    idle(20);
    check("rst_idle_pre_q", {16'd0, bus.pre_q}, 32'd0);
    check("rst_idle_div_q", {16'd0, bus.div_q}, 32'd0);

    // Basic period (pre 1, div 2)
    step(1, 0, 0, 1);
    step(0, 1, 0, 2);
    clear_pulses();
    wait_pulse("basic_first_timeout");
    check("basic_pend_after_pulse", {31'd0, bus.int_pend}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("basic_div_seq%0d", i), {16'd0, bus.div_q}, exp_seq[i]);
      step(0, 0, 0, 0);
    end
    check("basic_pulse_seq_end", {31'd0, bus.pit_int}, 32'd1);
    idle(14);
    check("basic_period", last_gap, 32'd6);

    // Ack without term
    wait_pulse("ack_wait_timeout");
    step(0, 0, 1, 0);
    check("ack_clears_pend", {31'd0, bus.int_pend}, 32'd0);
    check("ack_pit_int", {31'd0, bus.pit_int}, 32'd0);

    // div_wr on a term cycle
    goto_term("coll_div_timeout");
    step(0, 1, 0, 5);
    check("coll_div_no_int", {31'd0, bus.pit_int}, 32'd0);
    check("coll_div_q", {16'd0, bus.div_q}, 32'd5);

    // int_ack on a term cycle
    goto_term("coll_ack_timeout");
    step(0, 0, 1, 0);
    check("coll_ack_pend", {31'd0, bus.int_pend}, 32'd1);
    check("coll_ack_int", {31'd0, bus.pit_int}, 32'd1);

    // Minimum period
    step(1, 1, 0, 1);
    step(0, 1, 0, 0);
    clear_pulses();
    idle(20);
    check("min_period", last_gap, 32'd2);

    // Stop mid-count, then resume
    idle(1);
    step(1, 0, 0, 0);
    frz = m_div;
    clear_pulses();
    idle(100);
    check("stop_pulses", pulses, 32'd0);
    check("stop_pre_q", {16'd0, bus.pre_q}, 32'd0);
    check("stop_div_q", {16'd0, bus.div_q}, frz);
    step(0, 1, 0, 2);
    step(1, 0, 0, 3);
    clear_pulses();
    idle(40);
    check("resume_period", last_gap, 32'd12);

    // Asynchronous reset mid-count
    idle(5);
    #2;
    resl = 1'b0;
    model_reset();
    #1;
    check("arst_pre_q", {16'd0, bus.pre_q}, 32'd0);
    check("arst_div_q", {16'd0, bus.div_q}, 32'd0);
    check("arst_int_pend", {31'd0, bus.int_pend}, 32'd0);
    @(posedge clk);
    #1;
    resl = 1'b1;
    idle(10);
    check("arst_stays_stopped", {16'd0, bus.pre_q}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/pit_timer.md
# pit_timer

Programmable interval timer built from two cascaded 16-bit down-counters: a prescaler and a divider. The prescaler borrow clocks the divider, and the divider's terminal count raises an interrupt. The block sits downstream of the down-counter cell chain. It consumes the counter borrow/carry semantics, reloads the chain on terminal count and presents a one-cycle interrupt pulse plus a sticky pending flag to the interrupt controller.

## Interface
Parameters:
- none; all widths fixed at 16 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- resl  in  1  asynchronous active-low reset
- din  in  16  write data for reload registers
- pre_wr  in  1  load prescaler reload register and prescaler count from din
- div_wr  in  1  load divider reload register and divider count from din
- int_ack  in  1  clears int_pend
- pre_q  out  16  live prescaler count
- div_q  out  16  live divider count
- pit_int  out  1  registered one-cycle pulse per divider terminal count
- int_pend  out  1  sticky interrupt pending flag

## Operation
- State:
  - pre_rld, div_rld: reload registers.
  - pre_cnt, div_cnt: counts.
  - pit_int, int_pend: flags.
  - All reset to 0 asynchronously while resl low.
- run = (pre_rld != 0). With pre_rld = 0, both counts are frozen and no borrows or interrupts occur. Writes still take effect.
- Prescaler, when running:
  - pre_cnt != 0: pre_cnt decrements by 1.
  - pre_cnt == 0: pre_cnt reloads pre_rld and pre_bo = 1 for that cycle.
- Divider advances only on cycles with pre_bo = 1:
  - div_cnt != 0: div_cnt decrements by 1.
  - div_cnt == 0: div_cnt reloads div_rld and term = 1.
- Interrupt generation:
  - pit_int <= term & ~div_wr.
  - int_pend sets when term & ~div_wr.
  - int_pend clears on int_ack.
  - Set wins over simultaneous ack.
- Writes:
  - pre_wr: pre_rld <= din, pre_cnt <= din. This overrides that cycle's decrement/reload of pre_cnt.
  - pre_bo for that cycle is still computed from pre-write state, so the divider still steps if pre_cnt was 0 and run was 1.
  - div_wr: div_rld <= din, div_cnt <= din. Overrides the divider update and suppresses term's interrupt effect that cycle.
  - pre_wr and div_wr in the same cycle are independent; both apply.
- Period: with run = 1 and no writes, term asserts every (pre_rld+1)*(div_rld+1) clocks.
- div_rld = 0: term on every prescaler borrow.
- Arithmetic is unsigned 16-bit. Counts never wrap below 0; 0 always reloads. Max period is 65536*65536 clocks.
- pre_q = pre_cnt and div_q = div_cnt, unregistered beyond the count flops.

## Timing
- Reset: all outputs 0 immediately on resl low. First count step occurs on the first rising clk edge after resl high with pre_rld != 0.
- Write latency: 1 clock. The register and count hold din after the edge sampling the write. Decrementing resumes on the following edge.
- Interrupt latency: pit_int and int_pend go high on the edge after the cycle in which pre_cnt == 0 and div_cnt == 0. pit_int is high exactly one clock unless term recurs the next cycle (pre_rld = 0 cannot run, so the minimum spacing is 2 clocks when pre_rld = 1 and div_rld = 0).
- int_ack: int_pend low on the edge after int_ack, unless a term lands the same cycle.
- Writing pre_rld = 0 mid-count: counts freeze with pre_cnt = 0 on the next edge. A pending int_pend is unaffected.
- Reset mid-count: all state cleared. The timer stays stopped until pre_rld is rewritten.

## Test plan
- Reset: hold resl low with writes active -> pre_q = div_q = 0, pit_int = int_pend = 0; counts stay 0 for 20 clocks after release.
- Basic period: pre_wr din = 1, then div_wr din = 2 -> pit_int pulses every 6 clocks. div_q sequence 2,2,1,1,0,0 then reload. int_pend set after the first pulse.
- Minimum period: pre_rld = 1, div_rld = 0 -> pit_int every 2 clocks.
- Stop: pre_wr din = 0 mid-count -> pre_q = 0 and div_q frozen. No pit_int for 100 clocks. Rewriting pre_wr = 3 resumes with a period of 4*(div_rld+1).
- Collisions:
  - div_wr din = 5 on a term cycle -> no pit_int; div_q = 5 next clock.
  - int_ack on a term cycle -> int_pend stays 1.
- Ack: int_ack one clock with no term -> int_pend = 0 next edge; pit_int unaffected.
